// File: rtl/alu_muldiv_if.sv
// Handshake and operand bundle between the execute stage and the multiply/divide unit.
//   start/flush/funct3/aluIn1/aluIn2 : request side, driven by the pipeline (master)
//   busy/done/result                 : status and result, driven by the unit (slave)
interface alu_muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] aluIn1;
  logic [XLEN-1:0] aluIn2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, funct3, aluIn1, aluIn2,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, funct3, aluIn1, aluIn2,
    output busy, done, result
  );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit.
//   clk  : clock, rising edge
//   rstN : asynchronous active-low reset
//   bus  : alu_muldiv_if.slave (start, flush, funct3, aluIn1, aluIn2 in;
//          busy, done, result out)
// Magnitudes are processed unsigned over XLEN iterations (shift-add multiply, restoring divide),
// then a single sign-fix cycle produces the registered result.
module alu_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input logic         clk,
  input logic         rstN,
  alu_muldiv_if.slave bus
);

  localparam int unsigned CntW = $clog2(XLEN);

  localparam logic [2:0] F3Mul    = 3'b000;
  localparam logic [2:0] F3Mulh   = 3'b001;
  localparam logic [2:0] F3Mulhsu = 3'b010;
  localparam logic [2:0] F3Div    = 3'b100;
  localparam logic [2:0] F3Rem    = 3'b110;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // Multiply: {partial product high, multiplier shifting out}.
  // Divide:   {remainder, dividend shifting out / quotient shifting in}.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;   // multiplicand or divisor magnitude
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;   // final result must be negated
  logic [XLEN-1:0]   result_q, result_d;

  // Request decode
  logic            in_is_div, signed_a, signed_b, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b, special_result;
  logic            div_zero, div_ovf, special, in_neg, cnt_last;

  always_comb begin
    in_is_div = bus.funct3[2];
    signed_a  = (bus.funct3 == F3Mulh) || (bus.funct3 == F3Mulhsu) ||
                (bus.funct3 == F3Div)  || (bus.funct3 == F3Rem);
    signed_b  = (bus.funct3 == F3Mulh) || (bus.funct3 == F3Div) || (bus.funct3 == F3Rem);
    neg_a     = signed_a & bus.aluIn1[XLEN-1];
    neg_b     = signed_b & bus.aluIn2[XLEN-1];
    mag_a     = neg_a ? -bus.aluIn1 : bus.aluIn1;
    mag_b     = neg_b ? -bus.aluIn2 : bus.aluIn2;
    div_zero  = (bus.aluIn2 == '0);
    div_ovf   = signed_b && (bus.aluIn1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.aluIn2 == '1);
    special   = in_is_div & (div_zero | div_ovf);
    if (div_zero) special_result = bus.funct3[1] ? bus.aluIn1 : '1;
    else          special_result = bus.funct3[1] ? '0 : bus.aluIn1;
    // Remainder follows the dividend's sign; everything else follows the sign product.
    in_neg    = (in_is_div && bus.funct3[1]) ? neg_a : (neg_a ^ neg_b);
    cnt_last  = (cnt_q == CntW'(XLEN - 1));
  end

  // Iteration datapath
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step, div_step;
  logic [XLEN:0]     div_shift;
  logic [XLEN-1:0]   div_diff;
  logic              div_borrow;

  always_comb begin
    mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_step   = {mul_sum, acc_q[XLEN-1:1]};
    div_shift  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_borrow = (div_shift < {1'b0, opb_q});
    div_diff   = div_shift[XLEN-1:0] - opb_q;
    div_step   = div_borrow ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                            : {div_diff,            acc_q[XLEN-2:0], 1'b1};
  end

  // Sign correction
  logic [2*XLEN-1:0] mul_fix;
  logic [XLEN-1:0]   div_raw, div_fix, fix_result;

  always_comb begin
    mul_fix = neg_q ? -acc_q : acc_q;
    div_raw = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    div_fix = neg_q ? -div_raw : div_raw;
    if (op_q[2])              fix_result = div_fix;
    else if (op_q == F3Mul)   fix_result = mul_fix[XLEN-1:0];
    else                      fix_result = mul_fix[2*XLEN-1:XLEN];
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.start) state_d = special ? StDone : StCalc;
      StCalc: if (cnt_last)  state_d = StFix;
      StFix:                 state_d = StDone;
      StDone:                state_d = StIdle;
    endcase
    if (bus.flush) state_d = StIdle;
  end

  // FSM: outputs
  always_comb begin
    bus.busy   = (state_q != StIdle);
    bus.done   = (state_q == StDone);
    bus.result = result_q;
  end

  // Datapath next state; a flush freezes everything, including the result.
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    if (!bus.flush) begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            op_d  = bus.funct3;
            neg_d = in_neg;
            cnt_d = '0;
            opb_d = in_is_div ? mag_b : mag_a;
            acc_d = {{XLEN{1'b0}}, (in_is_div ? mag_a : mag_b)};
            if (special) result_d = special_result;
          end
        end
        StCalc: begin
          cnt_d = cnt_q + 1'b1;
          acc_d = op_q[2] ? div_step : mul_step;
        end
        StFix:  result_d = fix_result;
        StDone: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

endmodule
